// File: rtl/univ_reg.sv
// univ_reg: parametrised universal register with load, shift, rotate and count.
//
// Parameters:
//   W       register width, 2..32
//   RST_VAL value taken on async reset and on synchronous clear
// Ports:
//   C    clock, rising edge active
//   aRn  asynchronous reset, active-low (Q = RST_VAL, CO = 0)
//   CLR  synchronous clear, overrides E and M
//   E    clock enable; when low, Q and CO hold
//   M    mode: 0 hold, 1 load, 2 shl, 3 shr, 4 rol, 5 ror, 6 inc, 7 dec
//   D    parallel load data
//   SIL  serial input into Q[0] on shift left
//   SIR  serial input into Q[W-1] on shift right
//   Q    register contents (registered)
//   CO   carry / borrow / shifted-out bit (registered)
//   Z    combinational zero flag of Q
module univ_reg #(
  parameter int unsigned   W       = 4,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         C,
  input  logic         aRn,
  input  logic         CLR,
  input  logic         E,
  input  logic [2:0]   M,
  input  logic [W-1:0] D,
  input  logic         SIL,
  input  logic         SIR,
  output logic [W-1:0] Q,
  output logic         CO,
  output logic         Z
);

  localparam int unsigned MW = 3;

  typedef enum logic [MW-1:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

  logic [W-1:0] q_nxt;
  logic         co_nxt;

  // Next-state selection: CLR first, then enable, then mode.
  always_comb begin
    q_nxt  = Q;
    co_nxt = CO;
    if (CLR) begin
      q_nxt  = RST_VAL;
      co_nxt = 1'b0;
    end else if (E) begin
      case (mode_e'(M))
        MODE_HOLD: begin
          q_nxt  = Q;
          co_nxt = CO;
        end
        MODE_LOAD: begin
          q_nxt  = D;
          co_nxt = 1'b0;
        end
        MODE_SHL: begin
          q_nxt  = {Q[W-2:0], SIL};
          co_nxt = Q[W-1];
        end
        MODE_SHR: begin
          q_nxt  = {SIR, Q[W-1:1]};
          co_nxt = Q[0];
        end
        MODE_ROL: begin
          q_nxt  = {Q[W-2:0], Q[W-1]};
          co_nxt = Q[W-1];
        end
        MODE_ROR: begin
          q_nxt  = {Q[0], Q[W-1:1]};
          co_nxt = Q[0];
        end
        MODE_INC: begin
          q_nxt  = Q + W'(1);
          co_nxt = &Q;
        end
        MODE_DEC: begin
          q_nxt  = Q - W'(1);
          co_nxt = ~|Q;
        end
        default: begin
          q_nxt  = Q;
          co_nxt = CO;
        end
      endcase
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge C or negedge aRn) begin
    if (!aRn) begin
      Q  <= RST_VAL;
      CO <= 1'b0;
    end else begin
      Q  <= q_nxt;
      CO <= co_nxt;
    end
  end

  // Zero flag follows Q directly, including during reset.
  assign Z = ~|Q;

endmodule

// File: tb/tb_univ_reg.sv
// tb_univ_reg: directed plus randomized check of univ_reg against an
// arithmetic reference model (W = 4, RST_VAL = 4'hA).
module tb_univ_reg;

  localparam int unsigned W    = 4;
  localparam int unsigned FULL = 1 << W;
  localparam int unsigned HALF = FULL / 2;
  localparam logic [W-1:0] RV  = 4'hA;

  logic         C   = 1'b0;
  logic         aRn = 1'b1;
  logic         CLR = 1'b0;
  logic         E   = 1'b0;
  logic [2:0]   M   = 3'd0;
  logic [W-1:0] D   = '0;
  logic         SIL = 1'b0;
  logic         SIR = 1'b0;
  logic [W-1:0] Q;
  logic         CO;
  logic         Z;

  int checks   = 0;
  int failures = 0;

  // Reference state
  int unsigned q_m  = 0;
  int unsigned co_m = 0;

  univ_reg #(.W(W), .RST_VAL(RV)) dut (
    .C(C), .aRn(aRn), .CLR(CLR), .E(E), .M(M), .D(D),
    .SIL(SIL), .SIR(SIR), .Q(Q), .CO(CO), .Z(Z)
  );

  always #5 C = ~C;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of one rising edge, written as plain integer arithmetic.
  task automatic model_edge();
    int unsigned q;
    q = q_m;
    if (CLR) begin
      q_m  = RV;
      co_m = 0;
    end else if (E) begin
      case (int'(M))
        1: begin q_m = D; co_m = 0; end
        2: begin co_m = q / HALF; q_m = (q * 2 + SIL) % FULL; end
        3: begin co_m = q % 2; q_m = q / 2 + SIR * HALF; end
        4: begin co_m = q / HALF; q_m = (q * 2 + q / HALF) % FULL; end
        5: begin co_m = q % 2; q_m = q / 2 + (q % 2) * HALF; end
        6: begin co_m = (q == FULL - 1) ? 1 : 0; q_m = (q + 1) % FULL; end
        7: begin co_m = (q == 0) ? 1 : 0; q_m = (q + FULL - 1) % FULL; end
        default: ;
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".q"},  32'(Q),  32'(q_m));
    chk({tag, ".co"}, 32'(CO), 32'(co_m));
    chk({tag, ".z"},  32'(Z),  (q_m == 0) ? 32'd1 : 32'd0);
  endtask

  // Apply one clock edge; inputs are already stable, sample 1 time unit later.
  task automatic tick(input string tag);
    model_edge();
    @(posedge C);
    #1;
    check_model(tag);
  endtask

  // Pulse aRn low between edges and verify the immediate reset response.
  task automatic async_reset_pulse(input string tag);
    #2 aRn = 1'b0;
    q_m  = RV;
    co_m = 0;
    #1;
    chk({tag, ".q"},  32'(Q),  32'(RV));
    chk({tag, ".co"}, 32'(CO), 32'd0);
    check_model(tag);
    #1 aRn = 1'b1;
  endtask

  task automatic load(input logic [W-1:0] v);
    CLR = 1'b0; E = 1'b1; M = 3'b001; D = v;
    tick("load");
  endtask

  initial begin
    // Reset without any clock edge.
    #2 aRn = 1'b0;
    q_m = RV; co_m = 0;
    #1;
    chk("rst.q", 32'(Q), 32'hA);
    chk("rst.co", 32'(CO), 32'd0);
    chk("rst.z", 32'(Z), 32'd0);
    @(posedge C);
    #2 aRn = 1'b1;

    // Disabled edges hold the reset value.
    E = 1'b0; M = 3'b110;
    for (int i = 0; i < 3; i++) begin
      tick("hold_e0");
      chk("hold_e0.const", 32'(Q), 32'hA);
    end

    // Load then clear that wins over E = 0.
    load(4'h5);
    chk("load5.q", 32'(Q), 32'h5);
    chk("load5.z", 32'(Z), 32'd0);
    CLR = 1'b1; E = 1'b0; M = 3'b001; D = 4'hF;
    tick("clr");
    chk("clr.q", 32'(Q), 32'hA);
    chk("clr.co", 32'(CO), 32'd0);
    CLR = 1'b0;

    // Increment wrap.
    load(4'hE);
    M = 3'b110;
    tick("inc1");
    chk("inc1.q", 32'(Q), 32'hF);
    chk("inc1.co", 32'(CO), 32'd0);
    tick("inc2");
    chk("inc2.q", 32'(Q), 32'h0);
    chk("inc2.co", 32'(CO), 32'd1);
    chk("inc2.z", 32'(Z), 32'd1);
    M = 3'b000;
    tick("inc_hold");
    chk("inc_hold.co", 32'(CO), 32'd1);

    // Decrement borrow.
    load(4'h1);
    M = 3'b111;
    tick("dec1");
    chk("dec1.q", 32'(Q), 32'h0);
    chk("dec1.co", 32'(CO), 32'd0);
    tick("dec2");
    chk("dec2.q", 32'(Q), 32'hF);
    chk("dec2.co", 32'(CO), 32'd1);

    // Shift and rotate.
    load(4'b1001);
    M = 3'b010; SIL = 1'b1;
    tick("shl");
    chk("shl.q", 32'(Q), 32'b0011);
    chk("shl.co", 32'(CO), 32'd1);
    M = 3'b011; SIR = 1'b0;
    tick("shr");
    chk("shr.q", 32'(Q), 32'b0001);
    chk("shr.co", 32'(CO), 32'd1);
    load(4'b1001);
    M = 3'b100;
    for (int i = 0; i < 4; i++) tick("rol");
    chk("rol4.q", 32'(Q), 32'b1001);
    M = 3'b101;
    for (int i = 0; i < 4; i++) tick("ror");
    chk("ror4.q", 32'(Q), 32'b1001);

    // Enable gating during a count, then mid-cycle reset.
    load(4'h0);
    M = 3'b110;
    E = 1'b1; tick("gate1"); chk("gate1.q", 32'(Q), 32'h1);
    E = 1'b0; tick("gate0"); chk("gate0.q", 32'(Q), 32'h1);
    E = 1'b1; tick("gate2"); chk("gate2.q", 32'(Q), 32'h2);
    async_reset_pulse("midrst");
    M = 3'b110; E = 1'b1;
    tick("post_rst");
    chk("post_rst.q", 32'(Q), 32'hB);

    // Randomized traffic with occasional clears and async resets.
    for (int i = 0; i < 400; i++) begin
      CLR = ($urandom_range(0, 15) == 0);
      E   = ($urandom_range(0, 3) != 0);
      M   = 3'($urandom_range(0, 7));
      D   = W'($urandom);
      SIL = 1'($urandom);
      SIR = 1'($urandom);
      if ($urandom_range(0, 31) == 0) async_reset_pulse("rnd_rst");
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/univ_reg.md
# univ_reg

Parametrised universal register: the next generation of the team's plain 4-bit load register. It adds configurable width and reset value, a synchronous clear, clock enable, and eight operating modes: hold, parallel load, logical shift left/right with serial fill, rotate left/right, increment and decrement. A registered carry/shift-out flag and a combinational zero flag are also provided. It is the general-purpose state element for datapath counters, shifters and serial converters on the EP4CE6 design.

## Interface
- W, default 4: register width in bits; legal range 2..32.
- RST_VAL, default 0: W-bit value loaded by async reset and by CLR.
- C  input  1  clock; all state updates on rising edge.
- aRn  input  1  asynchronous reset, active-low. Reset is asynchronous and active-low; the polarity and synchronicity are fixed.
- CLR  input  1  synchronous clear; highest synchronous priority.
- E  input  1  clock enable; when 0, all state holds.
- M  input  3  mode select (encoding below).
- D  input  W  parallel load data.
- SIL  input  1  serial bit shifted into Q[0] on shift left.
- SIR  input  1  serial bit shifted into Q[W-1] on shift right.
- Q  output  W  register contents.
- CO  output  1  registered carry / shifted-out bit.
- Z  output  1  combinational, 1 when Q == 0.

## Operation
- Priority: aRn low (async) > CLR > E == 0 > mode M.
- aRn low: Q = RST_VAL and CO = 0 immediately, independent of C. Both hold while aRn is low.
- CLR = 1 at an edge: Q <= RST_VAL and CO <= 0, regardless of E and M.
- E = 0 (CLR = 0): Q and CO hold.
- E = 1, mode M:
  - 000 hold: Q and CO unchanged.
  - 001 load: Q <= D; CO <= 0.
  - 010 shift left: Q <= {Q[W-2:0], SIL}; CO <= old Q[W-1].
  - 011 shift right: Q <= {SIR, Q[W-1:1]}; CO <= old Q[0].
  - 100 rotate left: Q <= {Q[W-2:0], Q[W-1]}; CO <= old Q[W-1].
  - 101 rotate right: Q <= {Q[0], Q[W-1:1]}; CO <= old Q[0].
  - 110 increment: Q <= (Q + 1) mod 2^W; CO <= 1 if old Q == all ones, else 0.
  - 111 decrement: Q <= (Q - 1) mod 2^W; CO <= 1 if old Q == 0 (borrow), else 0.
- All arithmetic is W bits unsigned; wrap-around is silent apart from CO.
- Z = ~|Q. It is valid in the same cycle Q changes and equals 1 during reset only if RST_VAL == 0.

## Timing
- Latency: one clock from the sampled inputs to Q and CO. Z is combinational from Q, with no added latency.
- All inputs except aRn are sampled on the rising edge of C only; glitches between edges are ignored.
- aRn assertion is asynchronous. Deassertion must meet recovery/removal to C; the first active edge is the first rising C with aRn high.
- Reset asserted mid-operation, e.g. during a count run: Q and CO go to the reset values within the same cycle. The operation does not resume until re-commanded.
- CLR and E change together: CLR wins even when E = 0.
- Mode changes take effect on the next edge. There is no pipeline and no state other than Q and CO.
- Rotate for W cycles returns the original Q. Shift for W cycles replaces Q entirely with serial input bits.

## Test plan
- Reset: W=4, RST_VAL=4'hA. Drive aRn low between edges -> Q=A, CO=0 without a clock edge. Release aRn, E=0 for 3 edges -> Q stays A.
- Load/clear priority: E=1, M=001, D=5 -> Q=5, Z=0. Next edge CLR=1, E=0, M=001, D=F -> Q=A, CO=0.
- Increment wrap: load E. Then M=110 for 2 edges -> Q=F with CO=0, then Q=0 with CO=1 and Z=1. Then M=000 -> CO stays 1.
- Decrement borrow: load 1, then M=111 for 2 edges -> Q=0 with CO=0, then Q=F with CO=1.
- Shift/rotate: load 4'b1001. M=010 with SIL=1 -> Q=0011, CO=1. M=011 with SIR=0 -> Q=0001, CO=1. M=100 four times from 1001 -> Q=1001.
- Enable gating and mid-op reset: M=110 with E toggling 1,0,1 from Q=0 -> Q=1,1,2. Pulse aRn low mid-cycle -> Q=A at once. After release with M=110, E=1 -> Q=B on the next edge.
